fd_de_pipe_regs: RTL and testbench

- Pipeline-register block that receives the hazard unit's stall/flush outputs (StallF, StallD, FlushD, FlushE).
- Holds the fetch PC, the Fetch/Decode register and the Decode/Execute register, and turns those requests into hold or bubble behaviour.
- Sits between instruction memory, decode/regfile and the execute stage of the vector processor pipeline.
- Exposes saturating stall/flush event counters for performance debug.

---
 rtl/fd_de_pipe_regs.sv | 143 ++++++++++++++
 tb/tb_fd_de_pipe_regs.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fd_de_pipe_regs.sv
// Fetch PC, Fetch/Decode and Decode/Execute pipeline registers driven by the
// hazard unit's stall/flush requests, plus saturating stall/flush event counters.
module fd_de_pipe_regs #(
    parameter int              PC_W     = 32,
    parameter int              INSTR_W  = 32,
    parameter int              RA_W     = 8,
    parameter int              DATA_W   = 32,
    parameter int              CTRL_W   = 12,
    parameter int              CNT_W    = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               StallF,
    input  logic               StallD,
    input  logic               FlushD,
    input  logic               FlushE,
    input  logic               BranchTakenE,
    input  logic [PC_W-1:0]    BranchTargetE,
    input  logic [INSTR_W-1:0] InstrF,
    output logic [PC_W-1:0]    PCF,
    output logic [INSTR_W-1:0] InstrD,
    output logic [PC_W-1:0]    PCPlus4D,
    output logic               ValidD,
    input  logic [DATA_W-1:0]  RD1D,
    input  logic [DATA_W-1:0]  RD2D,
    input  logic [RA_W-1:0]    RA1D,
    input  logic [RA_W-1:0]    RA2D,
    input  logic [RA_W-1:0]    WA3D,
    input  logic [CTRL_W-1:0]  CtrlD,
    output logic [DATA_W-1:0]  RD1E,
    output logic [DATA_W-1:0]  RD2E,
    output logic [RA_W-1:0]    RA1E,
    output logic [RA_W-1:0]    RA2E,
    output logic [RA_W-1:0]    WA3E,
    output logic [CTRL_W-1:0]  CtrlE,
    output logic [PC_W-1:0]    PCPlus4E,
    output logic               ValidE,
    output logic [CNT_W-1:0]   StallCount,
    output logic [CNT_W-1:0]   FlushCount
);

    logic [PC_W-1:0]    pcf_reg;
    logic [PC_W-1:0]    pcf_plus4;
    logic [INSTR_W-1:0] instr_d_reg;
    logic [PC_W-1:0]    pcplus4_d_reg;
    logic               valid_d_reg;
    logic [DATA_W-1:0]  rd1_e_reg, rd2_e_reg;
    logic [RA_W-1:0]    ra1_e_reg, ra2_e_reg, wa3_e_reg;
    logic [CTRL_W-1:0]  ctrl_e_reg;
    logic [PC_W-1:0]    pcplus4_e_reg;
    logic               valid_e_reg;

    assign pcf_plus4 = pcf_reg + PC_W'(4);

    // Branch redirect wins over a fetch stall so a taken branch is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcf_reg <= RESET_PC;
        end else if (BranchTakenE) begin
            pcf_reg <= BranchTargetE;
        end else if (!StallF) begin
            pcf_reg <= pcf_plus4;
        end
    end

    // A stall outranks a flush; the flush request is dropped in that cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_d_reg   <= '0;
            pcplus4_d_reg <= '0;
            valid_d_reg   <= 1'b0;
        end else if (StallD) begin
            instr_d_reg   <= instr_d_reg;
            pcplus4_d_reg <= pcplus4_d_reg;
            valid_d_reg   <= valid_d_reg;
        end else if (FlushD) begin
            instr_d_reg   <= '0;
            pcplus4_d_reg <= '0;
            valid_d_reg   <= 1'b0;
        end else begin
            instr_d_reg   <= InstrF;
            pcplus4_d_reg <= pcf_plus4;
            valid_d_reg   <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || FlushE) begin
            rd1_e_reg     <= '0;
            rd2_e_reg     <= '0;
            ra1_e_reg     <= '0;
            ra2_e_reg     <= '0;
            wa3_e_reg     <= '0;
            ctrl_e_reg    <= '0;
            pcplus4_e_reg <= '0;
            valid_e_reg   <= 1'b0;
        end else begin
            rd1_e_reg     <= RD1D;
            rd2_e_reg     <= RD2D;
            ra1_e_reg     <= RA1D;
            ra2_e_reg     <= RA2D;
            wa3_e_reg     <= WA3D;
            // An empty decode slot must never carry RegWrite/MemtoReg into E.
            ctrl_e_reg    <= valid_d_reg ? CtrlD : '0;
            pcplus4_e_reg <= pcplus4_d_reg;
            valid_e_reg   <= valid_d_reg;
        end
    end

    logic [1:0] cnt_evt;
    assign cnt_evt = {FlushE, StallD};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_reg <= '0;
                end else if (cnt_evt[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    endgenerate

    assign PCF        = pcf_reg;
    assign InstrD     = instr_d_reg;
    assign PCPlus4D   = pcplus4_d_reg;
    assign ValidD     = valid_d_reg;
    assign RD1E       = rd1_e_reg;
    assign RD2E       = rd2_e_reg;
    assign RA1E       = ra1_e_reg;
    assign RA2E       = ra2_e_reg;
    assign WA3E       = wa3_e_reg;
    assign CtrlE      = ctrl_e_reg;
    assign PCPlus4E   = pcplus4_e_reg;
    assign ValidE     = valid_e_reg;
    assign StallCount = g_cnt[0].cnt_reg;
    assign FlushCount = g_cnt[1].cnt_reg;

endmodule

// File: tb/tb_fd_de_pipe_regs.sv
// Directed-vector bench for fd_de_pipe_regs: reset, free-run, load-use stall,
// branch flush, stall/flush overlap, PC wrap and counter saturation.
module tb_fd_de_pipe_regs;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallF, StallD, FlushD, FlushE, BranchTakenE;
    logic [31:0] BranchTargetE, InstrF, PCF, InstrD, PCPlus4D, PCPlus4E;
    logic        ValidD, ValidE;
    logic [31:0] RD1D, RD2D, RD1E, RD2E;
    logic [7:0]  RA1D, RA2D, WA3D, RA1E, RA2E, WA3E;
    logic [11:0] CtrlD, CtrlE;
    logic [15:0] StallCount, FlushCount;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    fd_de_pipe_regs dut (
        .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD),
        .FlushD(FlushD), .FlushE(FlushE), .BranchTakenE(BranchTakenE),
        .BranchTargetE(BranchTargetE), .InstrF(InstrF), .PCF(PCF),
        .InstrD(InstrD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
        .RD1D(RD1D), .RD2D(RD2D), .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
        .CtrlD(CtrlD), .RD1E(RD1E), .RD2E(RD2E), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .CtrlE(CtrlE), .PCPlus4E(PCPlus4E), .ValidE(ValidE),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    // One clock edge; outputs are sampled 1ns later and instruction memory
    // returns 0xE0000000 | address for the new fetch PC.
    task automatic step();
        @(posedge clk);
        #1;
        InstrF = 32'hE000_0000 | PCF;
    endtask

    task automatic clear_ctl();
        StallF = 0; StallD = 0; FlushD = 0; FlushE = 0; BranchTakenE = 0;
    endtask

    task automatic test_reset();
        reset = 1; clear_ctl(); BranchTargetE = '0; InstrF = 32'h1234_5678;
        RD1D = 32'h1111_1111; RD2D = 32'h2222_2222;
        RA1D = 8'h11; RA2D = 8'h22; WA3D = 8'h33; CtrlD = 12'hABC;
        step(); step();
        nvec++; if (PCF !== 32'h0) begin nerr++; $display("FAIL reset_pcf: got %h exp %h", PCF, 32'h0); end
        nvec++; if (InstrD !== 32'h0) begin nerr++; $display("FAIL reset_instrd: got %h exp %h", InstrD, 32'h0); end
        nvec++; if (ValidD !== 1'b0) begin nerr++; $display("FAIL reset_validd: got %b exp 0", ValidD); end
        nvec++; if (ValidE !== 1'b0) begin nerr++; $display("FAIL reset_valide: got %b exp 0", ValidE); end
        nvec++; if (CtrlE !== 12'h0) begin nerr++; $display("FAIL reset_ctrle: got %h exp 000", CtrlE); end
        nvec++; if (RD1E !== 32'h0) begin nerr++; $display("FAIL reset_rd1e: got %h exp 0", RD1E); end
        nvec++; if ({StallCount, FlushCount} !== 32'h0) begin nerr++; $display("FAIL reset_counts: got %h/%h exp 0/0", StallCount, FlushCount); end
        $display("test_reset: PCF=%h ValidD=%b ValidE=%b", PCF, ValidD, ValidE);
    endtask

    task automatic test_free_run();
        reset = 0;
        step();
        nvec++; if (PCF !== 32'h4) begin nerr++; $display("FAIL free1_pcf: got %h exp %h", PCF, 32'h4); end
        nvec++; if (InstrD !== 32'hE000_0000) begin nerr++; $display("FAIL free1_instrd: got %h exp %h", InstrD, 32'hE000_0000); end
        nvec++; if (ValidD !== 1'b1) begin nerr++; $display("FAIL free1_validd: got %b exp 1", ValidD); end
        nvec++; if (PCPlus4D !== 32'h4) begin nerr++; $display("FAIL free1_pcplus4d: got %h exp %h", PCPlus4D, 32'h4); end
        nvec++; if (CtrlE !== 12'h0) begin nerr++; $display("FAIL free1_ctrle: got %h exp 000", CtrlE); end
        step();
        nvec++; if (PCF !== 32'h8) begin nerr++; $display("FAIL free2_pcf: got %h exp %h", PCF, 32'h8); end
        nvec++; if (InstrD !== 32'hE000_0004) begin nerr++; $display("FAIL free2_instrd: got %h exp %h", InstrD, 32'hE000_0004); end
        nvec++; if (ValidE !== 1'b1) begin nerr++; $display("FAIL free2_valide: got %b exp 1", ValidE); end
        nvec++; if (CtrlE !== 12'hABC) begin nerr++; $display("FAIL free2_ctrle: got %h exp abc", CtrlE); end
        nvec++; if (PCPlus4E !== 32'h4) begin nerr++; $display("FAIL free2_pcplus4e: got %h exp %h", PCPlus4E, 32'h4); end
        nvec++; if ({RD1E, RD2E} !== {32'h1111_1111, 32'h2222_2222}) begin nerr++; $display("FAIL free2_rde: got %h/%h exp 11111111/22222222", RD1E, RD2E); end
        nvec++; if ({RA1E, RA2E, WA3E} !== 24'h112233) begin nerr++; $display("FAIL free2_rae: got %h/%h/%h exp 11/22/33", RA1E, RA2E, WA3E); end
        step();
        nvec++; if (InstrD !== 32'hE000_0008) begin nerr++; $display("FAIL free3_instrd: got %h exp %h", InstrD, 32'hE000_0008); end
        $display("test_free_run: PCF=%h InstrD=%h ValidE=%b", PCF, InstrD, ValidE);
    endtask

    task automatic test_load_use();
        InstrF = 32'hA;
        step();
        nvec++; if (InstrD !== 32'hA) begin nerr++; $display("FAIL lu_load_instrd: got %h exp %h", InstrD, 32'hA); end
        StallF = 1; StallD = 1; FlushE = 1;
        step();
        clear_ctl();
        nvec++; if (PCF !== 32'h10) begin nerr++; $display("FAIL lu_pcf_hold: got %h exp %h", PCF, 32'h10); end
        nvec++; if (InstrD !== 32'hA) begin nerr++; $display("FAIL lu_instrd_hold: got %h exp %h", InstrD, 32'hA); end
        nvec++; if (ValidE !== 1'b0) begin nerr++; $display("FAIL lu_valide: got %b exp 0", ValidE); end
        nvec++; if (CtrlE !== 12'h0) begin nerr++; $display("FAIL lu_ctrle: got %h exp 000", CtrlE); end
        nvec++; if ({RD1E, WA3E} !== 40'h0) begin nerr++; $display("FAIL lu_bubble_data: got %h/%h exp 0/0", RD1E, WA3E); end
        nvec++; if (StallCount !== 16'd1) begin nerr++; $display("FAIL lu_stallcount: got %0d exp 1", StallCount); end
        nvec++; if (FlushCount !== 16'd1) begin nerr++; $display("FAIL lu_flushcount: got %0d exp 1", FlushCount); end
        step();
        nvec++; if (PCPlus4E !== 32'h10) begin nerr++; $display("FAIL lu_resume_pcplus4e: got %h exp %h", PCPlus4E, 32'h10); end
        nvec++; if (ValidE !== 1'b1) begin nerr++; $display("FAIL lu_resume_valide: got %b exp 1", ValidE); end
        nvec++; if (PCF !== 32'h14) begin nerr++; $display("FAIL lu_resume_pcf: got %h exp %h", PCF, 32'h14); end
        $display("test_load_use: PCF=%h PCPlus4E=%h StallCount=%0d", PCF, PCPlus4E, StallCount);
    endtask

    task automatic test_branch();
        BranchTakenE = 1; BranchTargetE = 32'h100; FlushD = 1; FlushE = 1;
        step();
        clear_ctl();
        nvec++; if (PCF !== 32'h100) begin nerr++; $display("FAIL br_pcf: got %h exp %h", PCF, 32'h100); end
        nvec++; if ({ValidD, ValidE} !== 2'b00) begin nerr++; $display("FAIL br_valid: got %b%b exp 00", ValidD, ValidE); end
        nvec++; if ({InstrD, PCPlus4D} !== 64'h0) begin nerr++; $display("FAIL br_fd_bubble: got %h/%h exp 0/0", InstrD, PCPlus4D); end
        nvec++; if (FlushCount !== 16'd2) begin nerr++; $display("FAIL br_flushcount: got %0d exp 2", FlushCount); end
        step();
        nvec++; if (InstrD !== 32'hE000_0100) begin nerr++; $display("FAIL br_target_instrd: got %h exp %h", InstrD, 32'hE000_0100); end
        nvec++; if (PCPlus4D !== 32'h104) begin nerr++; $display("FAIL br_target_pcplus4d: got %h exp %h", PCPlus4D, 32'h104); end
        nvec++; if (CtrlE !== 12'h0) begin nerr++; $display("FAIL br_invalid_ctrle: got %h exp 000", CtrlE); end
        $display("test_branch: PCF=%h InstrD=%h ValidD=%b", PCF, InstrD, ValidD);
    endtask

    task automatic test_stall_over_flush();
        InstrF = 32'h55;
        step();
        StallD = 1; FlushD = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            nvec++; if (InstrD !== 32'h55) begin nerr++; $display("FAIL sf_instrd_%0d: got %h exp %h", i, InstrD, 32'h55); end
            nvec++; if (ValidD !== 1'b1) begin nerr++; $display("FAIL sf_validd_%0d: got %b exp 1", i, ValidD); end
        end
        nvec++; if (StallCount !== 16'd3) begin nerr++; $display("FAIL sf_stallcount: got %0d exp 3", StallCount); end
        clear_ctl();
        StallF = 1; BranchTakenE = 1; BranchTargetE = 32'h200;
        step();
        clear_ctl();
        nvec++; if (PCF !== 32'h200) begin nerr++; $display("FAIL sf_branch_over_stallf: got %h exp %h", PCF, 32'h200); end
        $display("test_stall_over_flush: InstrD=%h PCF=%h", InstrD, PCF);
    endtask

    task automatic test_pc_wrap();
        BranchTakenE = 1; BranchTargetE = 32'hFFFF_FFFC;
        step();
        clear_ctl();
        nvec++; if (PCF !== 32'hFFFF_FFFC) begin nerr++; $display("FAIL wrap_setup_pcf: got %h exp %h", PCF, 32'hFFFF_FFFC); end
        step();
        nvec++; if (PCF !== 32'h0) begin nerr++; $display("FAIL wrap_pcf: got %h exp %h", PCF, 32'h0); end
        nvec++; if (PCPlus4D !== 32'h0) begin nerr++; $display("FAIL wrap_pcplus4d: got %h exp %h", PCPlus4D, 32'h0); end
        $display("test_pc_wrap: PCF=%h PCPlus4D=%h", PCF, PCPlus4D);
    endtask

    task automatic test_saturation();
        StallD = 1; FlushE = 1;
        for (int i = 0; i < 65536 + 5; i++) @(posedge clk);
        #1;
        nvec++; if (StallCount !== 16'hFFFF) begin nerr++; $display("FAIL sat_stallcount: got %h exp ffff", StallCount); end
        nvec++; if (FlushCount !== 16'hFFFF) begin nerr++; $display("FAIL sat_flushcount: got %h exp ffff", FlushCount); end
        step();
        nvec++; if ({StallCount, FlushCount} !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL sat_nowrap: got %h/%h exp ffff/ffff", StallCount, FlushCount); end
        reset = 1;
        step();
        nvec++; if ({StallCount, FlushCount} !== 32'h0) begin nerr++; $display("FAIL sat_reset_counts: got %h/%h exp 0/0", StallCount, FlushCount); end
        nvec++; if (PCF !== 32'h0) begin nerr++; $display("FAIL sat_reset_pcf: got %h exp %h", PCF, 32'h0); end
        nvec++; if ({ValidD, ValidE} !== 2'b00) begin nerr++; $display("FAIL sat_reset_valid: got %b%b exp 00", ValidD, ValidE); end
        clear_ctl();
        reset = 0;
        step();
        nvec++; if ({PCF, ValidD} !== {32'h4, 1'b1}) begin nerr++; $display("FAIL sat_restart: got %h/%b exp 4/1", PCF, ValidD); end
        $display("test_saturation: StallCount=%h FlushCount=%h PCF=%h", StallCount, FlushCount, PCF);
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_load_use();
        test_branch();
        test_stall_over_flush();
        test_pc_wrap();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
